// File: rtl/writeback_pkg.sv
// Shared encodings for the writeback stage: result sources, load size codes,
// FSM states and the captured per-instruction control bundle.
package writeback_pkg;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic [2:0] funct3;
    logic [1:0] byte_off;
  } wb_ctrl_t;

  // Byte loads are always aligned; unknown size codes behave as word loads.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return off[0];
      default:       return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/half out of an aligned memory word and extends it
// to the datapath width according to the load size code.
module load_align_ext
  import writeback_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [3:0][7:0]  bytes;
  logic [1:0][15:0] halves;
  logic [7:0]       b;
  logic [15:0]      h;

  assign bytes  = word[31:0];
  assign halves = word[31:0];
  assign b      = bytes[byte_off];
  assign h      = halves[byte_off[1]];

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){b[7]}}, b};
      F3_LH:   data = {{(XLEN-16){h[15]}}, h};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: non-load results retire one cycle after acceptance, loads
// block in WAIT_RSP until the data-memory response arrives.
module writeback_unit
  import writeback_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5,
  parameter int CNT_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic                 m_reg_write,
  input  logic [RF_ADDR_W-1:0] m_rd,
  input  logic [1:0]           m_result_src,
  input  logic [2:0]           m_funct3,
  input  logic [1:0]           m_byte_off,
  input  logic [XLEN-1:0]      m_alu_result,
  input  logic [XLEN-1:0]      m_pc_plus4,
  input  logic [XLEN-1:0]      m_imm,
  input  logic                 dmem_rsp_valid,
  input  logic [XLEN-1:0]      dmem_rsp_data,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 load_misalign,
  output logic [CNT_W-1:0]     instret
);

  localparam int STAGES = 1;

  wb_state_e            state, state_nxt;
  wb_ctrl_t             ctrl_q;
  logic [RF_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]      opnd_sel, opnd_q, ld_data, wb_data;
  logic [STAGES:0]      vld_pipe;
  logic                 accept, is_load, cmp_ld, complete, misalign;

  assign accept      = m_valid & m_ready;
  assign is_load     = (m_result_src == SRC_LOAD);
  assign vld_pipe[0] = accept & ~is_load;

  // Load slot carries the address; it is never written back.
  always_comb begin
    opnd_sel = m_alu_result;
    case (m_result_src)
      SRC_ALU:  opnd_sel = m_alu_result;
      SRC_LOAD: opnd_sel = m_alu_result;
      SRC_PC4:  opnd_sel = m_pc_plus4;
      SRC_IMM:  opnd_sel = m_imm;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && is_load) state_nxt = WAIT_RSP;
      WAIT_RSP: if (dmem_rsp_valid)    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      opnd_q <= '0;
    end else if (accept) begin
      ctrl_q <= '{reg_write: m_reg_write, result_src: m_result_src,
                  funct3: m_funct3, byte_off: m_byte_off};
      rd_q   <= m_rd;
      opnd_q <= opnd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  load_align_ext #(.XLEN(XLEN)) u_align (
    .funct3   (ctrl_q.funct3),
    .byte_off (ctrl_q.byte_off),
    .word     (dmem_rsp_data),
    .data     (ld_data)
  );

  assign cmp_ld   = (state == WAIT_RSP) && dmem_rsp_valid && (ctrl_q.result_src == SRC_LOAD);
  assign misalign = cmp_ld && is_misaligned(ctrl_q.funct3, ctrl_q.byte_off);
  assign complete = vld_pipe[STAGES] | cmp_ld;
  assign wb_data  = cmp_ld ? ld_data : opnd_q;

  // A misaligned load retires nothing: address/data registers keep their last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we         <= 1'b0;
      rf_rd         <= '0;
      rf_wdata      <= '0;
      load_misalign <= 1'b0;
      instret       <= '0;
    end else begin
      rf_we         <= 1'b0;
      load_misalign <= misalign;
      if (complete && !misalign) begin
        rf_we    <= ctrl_q.reg_write && (rd_q != '0);
        rf_rd    <= rd_q;
        rf_wdata <= wb_data;
        instret  <= instret + 1'b1;
      end
    end
  end

endmodule
